// File: rtl/dmem_pkg.sv
// Shared encodings for the MEM-stage load/store unit: funct3 access widths
// and fault cause codes.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_RANGE    = 2'b10,
    CAUSE_ILLEGAL  = 2'b11
  } cause_e;

endpackage

// File: rtl/dmem_load_fmt.sv
// Load formatter: picks the addressed byte/halfword out of a memory word and
// sign- or zero-extends it to 32 bits according to funct3.
module dmem_load_fmt
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    result   = '0;
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_W:    result = word;
      F3_BU:   result = {24'h0, byte_sel};
      F3_HU:   result = {16'h0, half_sel};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// MEM-stage data memory with RISC-V B/H/W stores, sign/zero-extending loads,
// optional registered read and a sticky fault capture register.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS  = 64,
  parameter int ADDR_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] a,
  input  logic [31:0]       wd,
  output logic [31:0]       rd,
  output logic              rd_valid,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_addr,
  output logic [1:0]        fault_cause,
  input  logic              fault_clr
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(DEPTH_WORDS);

  // Zero at elaboration; reset deliberately leaves the contents alone.
  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             ld_legal, st_legal;
  logic             misalign, out_range;
  cause_e           ld_cause, st_cause, acc_cause;
  logic             st_ok, ld_ok, acc_err;
  logic [3:0]       wmask;
  logic [31:0]      wdata;
  logic [31:0]      rd_word, ld_data;

  assign idx  = a[IDX_W+1:2];
  assign lane = a[1:0];

  // Stores only accept the signed widths; BU/HU are load-only encodings.
  always_comb begin
    ld_legal = 1'b0;
    st_legal = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: begin
        ld_legal = 1'b1;
        st_legal = 1'b1;
      end
      F3_BU, F3_HU: ld_legal = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    misalign = 1'b0;
    if (funct3 == F3_H || funct3 == F3_HU) misalign = a[0];
    else if (funct3 == F3_W)               misalign = |a[1:0];
  end

  assign out_range = (a[ADDR_W-1:2] >= DEPTH_LIM);

  function automatic cause_e classify(input logic legal, input logic mis,
                                      input logic oor);
    if (!legal)   return CAUSE_ILLEGAL;
    else if (mis) return CAUSE_MISALIGN;
    else if (oor) return CAUSE_RANGE;
    else          return CAUSE_NONE;
  endfunction

  assign ld_cause = classify(ld_legal, misalign, out_range);
  assign st_cause = classify(st_legal, misalign, out_range);
  assign st_ok    = we && (st_cause == CAUSE_NONE);
  assign ld_ok    = re && (ld_cause == CAUSE_NONE);

  // Store-side cause dominates when both fire; it is never of lower priority.
  always_comb begin
    acc_cause = CAUSE_NONE;
    if (we && st_cause != CAUSE_NONE)      acc_cause = st_cause;
    else if (re && ld_cause != CAUSE_NONE) acc_cause = ld_cause;
  end
  assign acc_err = (acc_cause != CAUSE_NONE);

  always_comb begin
    wmask = 4'b0000;
    wdata = {4{wd[7:0]}};
    case (funct3)
      F3_B: wmask = 4'b0001 << lane;
      F3_H: begin
        wmask = a[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wd[15:0]}};
      end
      F3_W: begin
        wmask = 4'b1111;
        wdata = wd;
      end
      default: ;
    endcase
  end

  // The array ignores reset: a clean store in the reset cycle still lands.
  always_ff @(posedge clk) begin
    if (st_ok) begin
      for (int l = 0; l < 4; l++) begin
        if (wmask[l]) mem[idx][8*l +: 8] <= wdata[8*l +: 8];
      end
    end
  end

  assign rd_word = mem[idx];

  dmem_load_fmt u_fmt (
    .word   (rd_word),
    .lane   (lane),
    .funct3 (funct3),
    .result (ld_data)
  );

  // rd_valid qualifies rd for exactly one cycle per good load; there is no
  // back-pressure, the consumer must take rd whenever rd_valid is high.
  generate
    if (READ_LATENCY == 0) begin : g_comb_read
      assign rd       = ld_ok ? ld_data : 32'h0;
      assign rd_valid = ld_ok;
    end else begin : g_reg_read
      logic [31:0] rd_q;
      logic        rd_valid_q;

      // Array read sees pre-write contents, giving read-before-write.
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_q       <= '0;
          rd_valid_q <= 1'b0;
        end else if (re) begin
          rd_q       <= ld_ok ? ld_data : 32'h0;
          rd_valid_q <= ld_ok;
        end else begin
          rd_valid_q <= 1'b0;
        end
      end

      assign rd       = rd_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

  logic              fault_q;
  logic [ADDR_W-1:0] fault_addr_q;
  cause_e            fault_cause_q;

  // A new error in the clear cycle is captured rather than dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q       <= 1'b0;
      fault_addr_q  <= '0;
      fault_cause_q <= CAUSE_NONE;
    end else if (acc_err && (!fault_q || fault_clr)) begin
      fault_q       <= 1'b1;
      fault_addr_q  <= a;
      fault_cause_q <= acc_cause;
    end else if (fault_clr) begin
      fault_q       <= 1'b0;
      fault_addr_q  <= '0;
      fault_cause_q <= CAUSE_NONE;
    end
  end

  assign fault       = fault_q;
  assign fault_addr  = fault_addr_q;
  assign fault_cause = fault_cause_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: a registered-read and a combinational-read instance
// share stimulus and are checked against a byte-array reference model.
module tb_dmem_lsu;

  localparam int DEPTH = 64;
  localparam int NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0, re = 1'b0, clr = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] a = '0, wd = '0;

  logic [31:0] rd1, fa1, rd0, fa0;
  logic        rdv1, flt1, rdv0, flt0;
  logic [1:0]  fc1, fc0;

  int n_chk = 0;
  int n_pass = 0;

  // clock / reset
  always #5 clk = ~clk;

  dmem_lsu #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(rst), .we(we), .re(re), .funct3(f3), .a(a), .wd(wd),
    .rd(rd1), .rd_valid(rdv1), .fault(flt1), .fault_addr(fa1),
    .fault_cause(fc1), .fault_clr(clr)
  );

  dmem_lsu #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .READ_LATENCY(0)) dut0 (
    .clk(clk), .reset(rst), .we(we), .re(re), .funct3(f3), .a(a), .wd(wd),
    .rd(rd0), .rd_valid(rdv0), .fault(flt0), .fault_addr(fa0),
    .fault_cause(fc0), .fault_clr(clr)
  );

  // reference model
  logic [7:0]  mem_b [NBYTES];
  logic [31:0] m_rd = '0;
  logic        m_rdv = 1'b0;
  logic        m_flt = 1'b0;
  logic [31:0] m_fa = '0;
  logic [1:0]  m_fc = '0;
  logic [31:0] e0_rd;
  logic        e0_rdv;
  logic [31:0] exp_q[$];

  function automatic int classify(bit w, bit r, logic [2:0] f, logic [31:0] addr);
    bit st_ok, ld_ok;
    int size;
    st_ok = (f == 3'd0 || f == 3'd1 || f == 3'd2);
    ld_ok = st_ok || f == 3'd4 || f == 3'd5;
    if (!w && !r) return 0;
    if ((w && !st_ok) || (r && !ld_ok)) return 3;
    size = (f == 3'd2) ? 4 : (f == 3'd1 || f == 3'd5) ? 2 : 1;
    if (addr % size != 0) return 1;
    if (addr / 4 >= DEPTH) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] mload(logic [2:0] f, logic [31:0] addr);
    int i;
    longint v;
    i = int'(addr);
    case (f)
      3'd0: begin v = mem_b[i]; if (v >= 128) v -= 256; end
      3'd4: v = mem_b[i];
      3'd1: begin v = mem_b[i] + 256 * mem_b[i+1]; if (v >= 32768) v -= 65536; end
      3'd5: v = mem_b[i] + 256 * mem_b[i+1];
      default: v = mem_b[i] + 256 * mem_b[i+1] + 65536 * mem_b[i+2]
                   + 16777216 * longint'(mem_b[i+3]);
    endcase
    return v[31:0];
  endfunction

  task automatic mstore(logic [2:0] f, logic [31:0] addr, logic [31:0] d);
    int i, n;
    i = int'(addr);
    n = (f == 3'd2) ? 4 : (f == 3'd1) ? 2 : 1;
    for (int k = 0; k < n; k++) mem_b[i+k] = d[8*k +: 8];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // driver: apply one cycle of inputs, advance the model, check both instances
  task automatic step(input bit w, input bit r, input logic [2:0] f,
                      input logic [31:0] addr, input logic [31:0] d,
                      input bit c, input bit rs);
    int lerr, serr, aerr;
    @(negedge clk);
    we = w; re = r; f3 = f; a = addr; wd = d; clr = c; rst = rs;
    lerr = classify(1'b0, r, f, addr);
    serr = classify(w, 1'b0, f, addr);
    aerr = classify(w, r, f, addr);
    if (rs) begin
      m_rd = '0; m_rdv = 1'b0;
    end else if (r) begin
      m_rdv = (lerr == 0);
      m_rd  = (lerr == 0) ? mload(f, addr) : 32'h0;
    end else begin
      m_rdv = 1'b0;
    end
    exp_q.push_back(m_rd);
    if (w && serr == 0) mstore(f, addr, d);
    if (rs) begin
      m_flt = 1'b0; m_fa = '0; m_fc = '0;
    end else if (aerr != 0 && (!m_flt || c)) begin
      m_flt = 1'b1; m_fa = addr; m_fc = 2'(aerr);
    end else if (c) begin
      m_flt = 1'b0; m_fa = '0; m_fc = '0;
    end
    e0_rdv = r && (lerr == 0);
    e0_rd  = e0_rdv ? mload(f, addr) : 32'h0;
    @(posedge clk);
    #1;
    chk("rd_l1", rd1, exp_q.pop_front());
    chk("rd_valid_l1", {31'h0, rdv1}, {31'h0, m_rdv});
    chk("fault_l1", {31'h0, flt1}, {31'h0, m_flt});
    chk("fault_addr_l1", fa1, m_fa);
    chk("fault_cause_l1", {30'h0, fc1}, {30'h0, m_fc});
    chk("fault_l0", {31'h0, flt0}, {31'h0, m_flt});
    chk("fault_cause_l0", {30'h0, fc0}, {30'h0, m_fc});
    if (!rs) begin
      chk("rd_l0", rd0, e0_rd);
      chk("rd_valid_l0", {31'h0, rdv0}, {31'h0, e0_rdv});
    end
  endtask

  typedef struct {
    bit          we, re;
    logic [2:0]  f3;
    logic [31:0] a, wd;
    bit          clr;
    logic [31:0] e_rd;
    bit          e_rdv, e_flt;
    logic [31:0] e_fa;
    logic [1:0]  e_fc;
  } vec_t;

  vec_t tbl [23];

  initial begin
    for (int i = 0; i < NBYTES; i++) mem_b[i] = 8'h0;

    //          we re f3  a    wd            clr  e_rd          rdv flt fa   fc
    tbl[0]  = '{1, 0, 2, 0,   32'hDEADBEEF, 0,  32'h0,        0, 0, 0,   0};
    tbl[1]  = '{0, 1, 2, 0,   32'h0,        0,  32'hDEADBEEF, 1, 0, 0,   0};
    tbl[2]  = '{0, 1, 0, 3,   32'h0,        0,  32'hFFFFFFDE, 1, 0, 0,   0};
    tbl[3]  = '{0, 1, 4, 3,   32'h0,        0,  32'h000000DE, 1, 0, 0,   0};
    tbl[4]  = '{0, 1, 1, 2,   32'h0,        0,  32'hFFFFDEAD, 1, 0, 0,   0};
    tbl[5]  = '{0, 1, 5, 2,   32'h0,        0,  32'h0000DEAD, 1, 0, 0,   0};
    tbl[6]  = '{1, 0, 2, 4,   32'h11223344, 0,  32'h0000DEAD, 0, 0, 0,   0};
    tbl[7]  = '{1, 0, 0, 5,   32'h000000AA, 0,  32'h0000DEAD, 0, 0, 0,   0};
    tbl[8]  = '{0, 1, 2, 4,   32'h0,        0,  32'h1122AA44, 1, 0, 0,   0};
    tbl[9]  = '{1, 0, 1, 6,   32'h0000BEEF, 0,  32'h1122AA44, 0, 0, 0,   0};
    tbl[10] = '{0, 1, 2, 4,   32'h0,        0,  32'hBEEFAA44, 1, 0, 0,   0};
    tbl[11] = '{1, 0, 2, 2,   32'h12345678, 0,  32'hBEEFAA44, 0, 1, 2,   1};
    tbl[12] = '{0, 1, 2, 0,   32'h0,        0,  32'hDEADBEEF, 1, 1, 2,   1};
    tbl[13] = '{0, 1, 1, 1,   32'h0,        0,  32'h0,        0, 1, 2,   1};
    tbl[14] = '{0, 0, 0, 0,   32'h0,        1,  32'h0,        0, 0, 0,   0};
    tbl[15] = '{0, 1, 2, 256, 32'h0,        0,  32'h0,        0, 1, 256, 2};
    tbl[16] = '{0, 1, 3, 0,   32'h0,        0,  32'h0,        0, 1, 256, 2};
    tbl[17] = '{0, 0, 0, 0,   32'h0,        1,  32'h0,        0, 0, 0,   0};
    tbl[18] = '{0, 1, 3, 16,  32'h0,        0,  32'h0,        0, 1, 16,  3};
    tbl[19] = '{0, 1, 2, 6,   32'h0,        1,  32'h0,        0, 1, 6,   1};
    tbl[20] = '{0, 0, 0, 0,   32'h0,        1,  32'h0,        0, 0, 0,   0};
    tbl[21] = '{1, 1, 2, 8,   32'hCAFEBABE, 0,  32'h0,        1, 0, 0,   0};
    tbl[22] = '{0, 1, 2, 8,   32'h0,        0,  32'hCAFEBABE, 1, 0, 0,   0};

    // reset state
    step(0, 0, 3'd0, 32'h0, 32'h0, 0, 1);
    step(0, 0, 3'd0, 32'h0, 32'h0, 0, 1);
    chk("reset_rd", rd1, 32'h0);
    chk("reset_rd_valid", {31'h0, rdv1}, 32'h0);
    chk("reset_fault", {31'h0, flt1}, 32'h0);

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].we, tbl[i].re, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].clr, 0);
      chk($sformatf("vec%0d_rd", i), rd1, tbl[i].e_rd);
      chk($sformatf("vec%0d_rdv", i), {31'h0, rdv1}, {31'h0, tbl[i].e_rdv});
      chk($sformatf("vec%0d_fault", i), {31'h0, flt1}, {31'h0, tbl[i].e_flt});
      chk($sformatf("vec%0d_faddr", i), fa1, tbl[i].e_fa);
      chk($sformatf("vec%0d_fcause", i), {30'h0, fc1}, {30'h0, tbl[i].e_fc});
    end

    // reset with a pending load and a store in the reset cycle
    step(0, 1, 3'd2, 32'h3, 32'h0, 0, 0);
    step(0, 1, 3'd2, 32'h8, 32'h0, 0, 0);
    chk("pre_reset_rd", rd1, 32'hCAFEBABE);
    step(1, 1, 3'd2, 32'hC, 32'h5A5A1234, 0, 1);
    chk("mid_reset_rd", rd1, 32'h0);
    chk("mid_reset_rdv", {31'h0, rdv1}, 32'h0);
    chk("mid_reset_fault", {31'h0, flt1}, 32'h0);
    step(0, 1, 3'd2, 32'h4, 32'h0, 0, 0);
    chk("post_reset_word4", rd1, 32'hBEEFAA44);
    step(0, 1, 3'd2, 32'hC, 32'h0, 0, 0);
    chk("reset_cycle_store", rd1, 32'h5A5A1234);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] addr;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 8)      addr = $urandom_range(0, NBYTES - 1);
      else if (sel < 9) addr = $urandom_range(NBYTES, NBYTES + 64);
      else              addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           3'($urandom_range(0, 7)), addr, $urandom,
           $urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Parametrised successor to the single-port word data memory.
- Adds RISC-V byte/halfword/word stores with byte-lane enables.
- Adds sign/zero-extending loads, selectable 0/1-cycle read latency, and detection of misaligned, out-of-range and illegal-width accesses with a sticky fault capture register.
- Sits in the MEM stage of the pipelined core, driven by the ALU result address and funct3.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words; power of two, >= 4.
- ADDR_W, 32, byte-address width.
- READ_LATENCY, 1, 0 = combinational read; 1 = registered read with read-before-write.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- we  input  1  store request.
- re  input  1  load request.
- funct3  input  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- a  input  ADDR_W  byte address.
- wd  input  32  store data, right-aligned.
- rd  output  32  load data, extended to 32 bits.
- rd_valid  output  1  rd carries a good load result.
- fault  output  1  sticky: an access error has occurred.
- fault_addr  output  ADDR_W  address of the first captured error.
- fault_cause  output  2  01 misaligned, 10 out-of-range, 11 illegal funct3.
- fault_clr  input  1  clears the sticky fault state.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset values: rd=0, rd_valid=0, fault=0, fault_addr=0, fault_cause=00.
- The memory array is not cleared by reset. It is zero-initialised at elaboration, so unwritten words read 0.
- Indexing: word index = a[log2(DEPTH_WORDS)+1:2]. Byte order is little-endian; byte lane = a[1:0].
- Error classification per access (we|re); priority illegal funct3 > misaligned > out-of-range:
  - illegal: funct3 not in {000,001,010,100,101}; BU/HU are also illegal for stores.
  - misaligned: H/HU with a[0]=1, or W with a[1:0]!=0.
  - out-of-range: a[ADDR_W-1:2] >= DEPTH_WORDS.
- Store: on posedge with we=1 and no error, write only the selected lanes.
  - SB writes wd[7:0] to lane a[1:0].
  - SH writes wd[15:0] to lanes a[1]*2 and a[1]*2+1.
  - SW writes all four lanes.
  - An erroneous store is fully suppressed: no lane changes.
- Load extraction: B/H are sign-extended; BU/HU are zero-extended; an erroneous load returns rd=0 with rd_valid=0.
- READ_LATENCY=0:
  - rd and rd_valid are combinational from a, funct3, re and current array contents.
  - A same-address store becomes visible immediately after the write edge.
- READ_LATENCY=1:
  - rd and rd_valid are registered at the posedge where re is sampled, so valid one cycle later.
  - A simultaneous same-word we+re returns the pre-write data (read-before-write).
  - rd holds its last value when re=0, while rd_valid drops to 0.
- we and re high together: legal; the store and the load proceed independently.
- Sticky fault register:
  - The first erroneous access sets fault=1 and captures a and fault_cause on that posedge.
  - While fault=1, later errors do not overwrite the captured fields.
  - fault_clr=1 clears all fault fields on the next posedge.
  - fault_clr together with a new error in the same cycle: the new error is captured (set wins).
- Reset mid-operation: a pending registered read is discarded (rd_valid=0 the next cycle). A store in the reset cycle is still performed if error-free; the array is unaffected by reset otherwise.

Decomposition:
- Shared package dmem_pkg holds:
  - funct3 encodings F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - cause codes CAUSE_NONE, CAUSE_MISALIGN, CAUSE_RANGE, CAUSE_ILLEGAL.
- One sub-module, dmem_load_fmt: combinational lane select plus sign/zero extend (word, a[1:0], funct3 -> 32-bit result). The top module holds the array, store-lane mask, error classifier, read register and fault register.

Test Plan:
- SW 0xDEADBEEF @0x0, then LW/LB/LBU/LH/LHU @0x0, 0x3, 0x3, 0x2, 0x2 -> 0xDEADBEEF, 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000DEAD; with READ_LATENCY=1 each result and rd_valid appear one cycle after re.
- Word @0x4 holds 0x11223344; SB 0xAA @0x5 -> LW @0x4 returns 0x1122AA44; then SH 0xBEEF @0x6 -> LW returns 0xBEEFAA44.
- SW @0x2 (misaligned) -> memory unchanged, fault=1, fault_addr=0x2, cause=01. A later LH @0x1 -> rd_valid=0 and capture unchanged. fault_clr -> fault=0.
- LW @(DEPTH_WORDS*4) -> rd=0, rd_valid=0, cause=10. funct3=011 load -> cause=11 only after a fault_clr. fault_clr with a simultaneous new error -> new error is captured.
- READ_LATENCY=1, we+re same cycle @0x8: old 0x0, wd 0xCAFEBABE -> rd=0x00000000 next cycle; a re-read gives 0xCAFEBABE.
- Assert reset with re=1 pending -> rd=0, rd_valid=0, fault=0 the next cycle; a word written before reset still reads back intact.
